// File: rtl/pill_feed_ctrl_if.sv
// Signal bundle between the pill feed controller and its surroundings
// (sensors, counter stage, display page).
interface pill_feed_ctrl_if;
  logic       isWork;
  logic       conti;
  logic       pill_sense;
  logic       bottle_sense;
  logic       bottle_full;
  logic       allFull;
  logic       pill_tick;
  logic       gate_open;
  logic       conveyor_on;
  logic       bottle_done;
  logic       fault;
  logic [2:0] state_code;

  // Environment side: drives sensors and counter levels, observes drives.
  modport master (
    output isWork,
    output conti,
    output pill_sense,
    output bottle_sense,
    output bottle_full,
    output allFull,
    input  pill_tick,
    input  gate_open,
    input  conveyor_on,
    input  bottle_done,
    input  fault,
    input  state_code
  );

  // Controller side.
  modport slave (
    input  isWork,
    input  conti,
    input  pill_sense,
    input  bottle_sense,
    input  bottle_full,
    input  allFull,
    output pill_tick,
    output gate_open,
    output conveyor_on,
    output bottle_done,
    output fault,
    output state_code
  );
endinterface

// File: rtl/pill_feed_ctrl.sv
// Pill feed controller: debounces the pill-drop sensor into pill_tick pulses
// and sequences the pill gate and bottle conveyor around the counter stage.
module pill_feed_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned CONV_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic            CLK,
  input  logic            RST,
  pill_feed_ctrl_if.slave bus
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned CW = $clog2(CONV_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FILL  = 3'd2,
    S_ADV   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            ps1;
  logic            ps2;
  logic            bs1;
  logic            bs2;
  logic            filt;
  logic            filt_d;
  logic [DW-1:0]   dcnt;
  logic [TW-1:0]   tcnt;
  logic [CW-1:0]   ccnt;
  logic            is_work_d;
  logic            start;

  logic            gate_nxt;
  logic            conv_nxt;
  logic            done_nxt;
  logic            fault_nxt;

  logic            pill_tick;
  logic            gate_open;
  logic            conveyor_on;
  logic            bottle_done;
  logic            fault;

  assign start = bus.isWork & ~is_work_d;

  // Two-flop synchronizers for both raw sensors, plus run-enable edge history.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ps1       <= 1'b0;
      ps2       <= 1'b0;
      bs1       <= 1'b0;
      bs2       <= 1'b0;
      is_work_d <= 1'b0;
    end else begin
      ps1       <= bus.pill_sense;
      ps2       <= ps1;
      bs1       <= bus.bottle_sense;
      bs2       <= bs1;
      is_work_d <= bus.isWork;
    end
  end

  // Pill debounce: a new level is accepted only after DEBOUNCE_CYC agreeing samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt   <= 1'b0;
      filt_d <= 1'b0;
      dcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (ps2 != filt) begin
        if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
          filt <= ps2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next-cycle drive decode.
  always_comb begin
    state_nxt = state;
    gate_nxt  = 1'b0;
    conv_nxt  = 1'b0;
    done_nxt  = 1'b0;
    fault_nxt = 1'b0;

    if (!bus.isWork) begin
      state_nxt = S_IDLE;
    end else if (bus.allFull &&
                 (state == S_WAIT || state == S_FILL || state == S_ADV)) begin
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (bs2) begin
            state_nxt = S_FILL;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state_nxt = S_FAULT;
          end
        end
        S_FILL: begin
          // A full bottle takes precedence over a simultaneous bottle loss.
          if (bus.bottle_full) begin
            state_nxt = S_ADV;
          end else if (!bs2) begin
            state_nxt = S_FAULT;
          end
        end
        S_ADV: begin
          if (ccnt == CW'(CONV_CYC - 1)) begin
            state_nxt = bus.conti ? S_WAIT : S_IDLE;
          end
        end
        default: state_nxt = state;
      endcase
    end

    gate_nxt  = (state_nxt == S_FILL);
    conv_nxt  = (state_nxt == S_WAIT) || (state_nxt == S_ADV);
    done_nxt  = (state == S_FILL) && (state_nxt == S_ADV);
    fault_nxt = (state_nxt == S_FAULT);
  end

  // Residency counters: restart whenever the state is (re)entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt <= '0;
      ccnt <= '0;
    end else begin
      if (state == S_WAIT && state_nxt == S_WAIT) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end
      if (state == S_ADV && state_nxt == S_ADV) begin
        ccnt <= ccnt + CW'(1);
      end else begin
        ccnt <= '0;
      end
    end
  end

  // Registered drives; filt rising edges outside FILL are simply dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pill_tick   <= 1'b0;
      gate_open   <= 1'b0;
      conveyor_on <= 1'b0;
      bottle_done <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pill_tick   <= filt & ~filt_d & (state == S_FILL);
      gate_open   <= gate_nxt;
      conveyor_on <= conv_nxt;
      bottle_done <= done_nxt;
      fault       <= fault_nxt;
    end
  end

  assign bus.pill_tick   = pill_tick;
  assign bus.gate_open   = gate_open;
  assign bus.conveyor_on = conveyor_on;
  assign bus.bottle_done = bottle_done;
  assign bus.fault       = fault;
  assign bus.state_code  = 3'(state);

endmodule

// File: tb/tb_pill_feed_ctrl.sv
// Bench for pill_feed_ctrl: directed vector table, hand-written pill/fault
// sequences, and randomized traffic, all checked against a behavioural model.
module tb_pill_feed_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned CONV = 8;
  localparam int unsigned TMO  = 64;

  logic CLK;
  logic RST;

  pill_feed_ctrl_if bus();

  pill_feed_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .CONV_CYC     (CONV),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: sensor history lines, a run of disagreeing pill samples,
  // and the spec's state code with the number of cycles spent in that state.
  bit ps_h[2];
  bit bs_h[2];
  bit dq[$];
  bit m_filt;
  bit m_rose;
  bit m_prev_work;
  int m_st;
  int m_age;
  bit o_tick, o_gate, o_conv, o_done, o_fault;
  int o_code;

  task automatic model_step();
    bit ps2;
    bit bs2;
    bit start;
    int nx;
    if (RST) begin
      ps_h = '{0, 0};
      bs_h = '{0, 0};
      dq.delete();
      m_filt = 0; m_rose = 0; m_prev_work = 0;
      m_st = 0; m_age = 0;
      o_tick = 0; o_gate = 0; o_conv = 0; o_done = 0; o_fault = 0; o_code = 0;
      return;
    end
    ps2   = ps_h[1];
    bs2   = bs_h[1];
    start = bus.isWork && !m_prev_work;

    o_tick = m_rose && (m_st == 2);
    m_rose = 0;
    if (ps2 != m_filt) dq.push_back(ps2);
    else dq.delete();
    if (dq.size() >= DEB) begin
      m_filt = ps2;
      m_rose = ps2;
      dq.delete();
    end

    nx = m_st;
    if (!bus.isWork) nx = 0;
    else if (bus.allFull && m_st >= 1 && m_st <= 3) nx = 4;
    else if (m_st == 0 && start) nx = 1;
    else if (m_st == 1 && bs2) nx = 2;
    else if (m_st == 1 && m_age == TMO - 1) nx = 5;
    else if (m_st == 2 && bus.bottle_full) nx = 3;
    else if (m_st == 2 && !bs2) nx = 5;
    else if (m_st == 3 && m_age == CONV - 1) nx = bus.conti ? 1 : 0;

    o_gate  = (nx == 2);
    o_conv  = (nx == 1) || (nx == 3);
    o_done  = (m_st == 2) && (nx == 3);
    o_fault = (nx == 5);
    o_code  = nx;
    m_age   = (nx == m_st) ? m_age + 1 : 0;
    m_st    = nx;

    ps_h[1] = ps_h[0]; ps_h[0] = bus.pill_sense;
    bs_h[1] = bs_h[0]; bs_h[0] = bus.bottle_sense;
    m_prev_work = bus.isWork;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare all outputs on the falling edge.
  task automatic cycle();
    logic [7:0] act;
    logic [7:0] exp;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    act = {bus.pill_tick, bus.gate_open, bus.conveyor_on, bus.bottle_done,
           bus.fault, bus.state_code};
    exp = {o_tick, o_gate, o_conv, o_done, o_fault, 3'(o_code)};
    chk("model", 32'(act), 32'(exp));
  endtask

  task automatic run(input int n, output int nt);
    nt = 0;
    repeat (n) begin
      cycle();
      if (bus.pill_tick === 1'b1) nt++;
    end
  endtask

  task automatic set_in(input int w, input int c, input int p, input int b,
                        input int f, input int a);
    bus.isWork       = (w != 0);
    bus.conti        = (c != 0);
    bus.pill_sense   = (p != 0);
    bus.bottle_sense = (b != 0);
    bus.bottle_full  = (f != 0);
    bus.allFull      = (a != 0);
  endtask

  typedef struct {
    int work, conti, pill, bottle, full, allf;
    int cyc;
    int st, gate, conv, flt;
  } vec_t;

  vec_t tbl[26];

  initial begin
    int nt;
    int tot;
    int first;
    int p_run;
    int b_run;
    bit pill;
    bit bottle;
    bit conti;

    tbl[0]  = '{0,0,0,0,0,0,  3, 0,0,0,0};
    tbl[1]  = '{1,1,0,0,0,0,  1, 1,0,1,0};
    tbl[2]  = '{1,1,0,1,0,0,  3, 2,1,0,0};
    tbl[3]  = '{1,1,0,1,1,0,  1, 3,0,1,0};
    tbl[4]  = '{1,1,0,1,0,0,  7, 3,0,1,0};
    tbl[5]  = '{1,1,0,1,0,0,  1, 1,0,1,0};
    tbl[6]  = '{1,1,0,1,0,0,  1, 2,1,0,0};
    tbl[7]  = '{1,0,0,1,1,0,  1, 3,0,1,0};
    tbl[8]  = '{1,0,0,1,0,0,  8, 0,0,0,0};
    tbl[9]  = '{1,0,0,1,0,0,  5, 0,0,0,0};
    tbl[10] = '{0,0,0,0,0,0,  3, 0,0,0,0};
    tbl[11] = '{1,0,0,0,0,0,  1, 1,0,1,0};
    tbl[12] = '{1,0,0,0,0,0, 63, 1,0,1,0};
    tbl[13] = '{1,0,0,0,0,0,  1, 5,0,0,1};
    tbl[14] = '{0,0,0,0,0,0,  1, 0,0,0,0};
    tbl[15] = '{1,0,0,1,0,0,  1, 1,0,1,0};
    tbl[16] = '{1,0,0,1,0,0,  2, 2,1,0,0};
    tbl[17] = '{1,0,0,0,0,0,  2, 2,1,0,0};
    tbl[18] = '{1,0,0,0,0,0,  1, 5,0,0,1};
    tbl[19] = '{0,0,0,1,0,0,  1, 0,0,0,0};
    tbl[20] = '{1,0,0,1,0,0,  3, 2,1,0,0};
    tbl[21] = '{1,0,0,0,0,0,  2, 2,1,0,0};
    tbl[22] = '{1,0,0,0,1,0,  1, 3,0,1,0};
    tbl[23] = '{1,0,0,0,0,1,  1, 4,0,0,0};
    tbl[24] = '{1,0,0,0,0,0,  5, 4,0,0,0};
    tbl[25] = '{0,0,0,0,0,0,  1, 0,0,0,0};

    // Reset: all drives low while RST is held.
    set_in(0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    cycle();
    cycle();
    chk("reset_outs", 32'({bus.pill_tick, bus.gate_open, bus.conveyor_on,
                           bus.bottle_done, bus.fault, bus.state_code}), 32'd0);
    RST = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].work, tbl[i].conti, tbl[i].pill, tbl[i].bottle,
             tbl[i].full, tbl[i].allf);
      repeat (tbl[i].cyc) cycle();
      chk($sformatf("vec%0d_state", i), 32'(bus.state_code), 32'(tbl[i].st));
      chk($sformatf("vec%0d_gate", i), 32'(bus.gate_open), 32'(tbl[i].gate));
      chk($sformatf("vec%0d_conv", i), 32'(bus.conveyor_on), 32'(tbl[i].conv));
      chk($sformatf("vec%0d_fault", i), 32'(bus.fault), 32'(tbl[i].flt));
    end

    // Enter FILL and measure pill tick latency for a long pulse.
    set_in(0, 0, 0, 1, 0, 0);
    run(3, nt);
    set_in(1, 0, 0, 1, 0, 0);
    run(3, nt);
    chk("fill_entry", 32'(bus.state_code), 32'd2);
    first = -1;
    tot   = 0;
    bus.pill_sense = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) bus.pill_sense = 1'b0;
      cycle();
      if (bus.pill_tick === 1'b1) begin
        tot++;
        if (first < 0) first = k;
      end
    end
    chk("tick_latency", 32'(first), 32'(DEB + 2));
    chk("tick_long_count", 32'(tot), 32'd1);

    bus.pill_sense = 1'b1;
    run(3, nt);
    tot = nt;
    bus.pill_sense = 1'b0;
    run(10, nt);
    chk("tick_short_rejected", 32'(tot + nt), 32'd0);

    tot = 0;
    for (int k = 0; k < 5; k++) begin
      bus.pill_sense = 1'b1;
      run(6, nt);
      tot += nt;
      bus.pill_sense = 1'b0;
      run(6, nt);
      tot += nt;
    end
    run(8, nt);
    tot += nt;
    chk("tick_five_pulses", 32'(tot), 32'd5);

    // Bottle loss in FILL, then pill activity in FAULT must not tick.
    bus.bottle_sense = 1'b0;
    run(3, nt);
    chk("loss_fault_state", 32'(bus.state_code), 32'd5);
    tot = 0;
    for (int k = 0; k < 3; k++) begin
      bus.pill_sense = 1'b1;
      run(6, nt);
      tot += nt;
      bus.pill_sense = 1'b0;
      run(6, nt);
      tot += nt;
    end
    chk("fault_no_ticks", 32'(tot), 32'd0);
    chk("fault_held", 32'(bus.fault), 32'd1);
    bus.isWork = 1'b0;
    run(1, nt);
    chk("fault_clear_state", 32'(bus.state_code), 32'd0);
    chk("fault_clear_flag", 32'(bus.fault), 32'd0);

    // Randomized traffic, checked cycle by cycle against the model.
    pill   = 1'b0;
    bottle = 1'b0;
    conti  = 1'b1;
    p_run  = 0;
    b_run  = 0;
    for (int n = 0; n < 5000; n++) begin
      if (p_run == 0) begin
        pill  = ~pill;
        p_run = int'($urandom_range(1, 9));
      end
      p_run--;
      if (b_run == 0) begin
        bottle = ~bottle;
        b_run  = bottle ? int'($urandom_range(10, 90)) : int'($urandom_range(1, 8));
      end
      b_run--;
      if ($urandom_range(0, 49) == 0) conti = ~conti;
      bus.pill_sense   = pill;
      bus.bottle_sense = bottle;
      bus.conti        = conti;
      bus.isWork       = ($urandom_range(0, 99) != 0);
      bus.bottle_full  = ($urandom_range(0, 19) == 0);
      bus.allFull      = ($urandom_range(0, 249) == 0);
      RST              = ($urandom_range(0, 799) == 0);
      cycle();
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pill_feed_ctrl.md
Name: pill_feed_ctrl

Overview:
Upstream feed controller for the bottling counter stage. It debounces the raw pill-drop sensor and emits one-cycle pill_tick pulses for the counter to increment its per-bottle BCD count. It sequences the pill gate and bottle conveyor around the counter's bottle_full and allFull indications. It also exposes a state code for the display page.

Parameters:
DEBOUNCE_CYC, 4, consecutive synchronized cycles a pill_sense level must hold before it is accepted (>=2)
CONV_CYC, 8, cycles the conveyor runs after a bottle completes
TIMEOUT_CYC, 64, max cycles in WAIT_BOTTLE before FAULT

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
isWork  in  1  run enable level; low forces IDLE
conti  in  1  1 = continuous mode, 0 = single-bottle mode
pill_sense  in  1  raw asynchronous pill-drop sensor
bottle_sense  in  1  raw asynchronous bottle-in-place sensor
bottle_full  in  1  from counter: current bottle reached its pill max (level)
allFull  in  1  from counter: bottle quota reached (level)
pill_tick  out  1  one-cycle pulse per accepted pill
gate_open  out  1  pill gate drive
conveyor_on  out  1  conveyor motor drive
bottle_done  out  1  one-cycle pulse when a bottle completes
fault  out  1  high while in FAULT
state_code  out  3  IDLE=0, WAIT_BOTTLE=1, FILL=2, ADVANCE=3, DONE=4, FAULT=5

Behaviour:
- Reset: state IDLE; all outputs 0; sync flops, filtered level, counters, and isWork_d cleared.
- pill_sense and bottle_sense pass through 2-flop synchronizers (ps2, bs2). No debounce on bottle_sense.
- Debounce: if ps2 != filt, cnt++; when cnt == DEBOUNCE_CYC-1 and still differing, filt <= ps2, cnt <= 0. If ps2 == filt, cnt <= 0. Pulses shorter than DEBOUNCE_CYC cycles after the synchronizers are rejected.
- pill_tick is registered: high for exactly one cycle on a filt 0->1 transition, only if state == FILL. Latency: high after edge DEBOUNCE_CYC+2, counting the first edge that samples pill_sense=1 as edge 0.
- Rising edges of filt outside FILL are discarded; they are never queued.
- isWork_d is a registered copy of isWork. start = isWork & ~isWork_d.
- Global priority, highest first:
  1. RST
  2. isWork==0 -> IDLE (this also clears FAULT)
  3. allFull==1 in WAIT_BOTTLE/FILL/ADVANCE -> DONE
  4. per-state transition
- IDLE: all drives off. On start -> WAIT_BOTTLE.
- WAIT_BOTTLE: conveyor_on=1, gate closed, tcnt++.
  - bs2==1 -> FILL and tcnt <= 0.
  - tcnt == TIMEOUT_CYC-1 with bs2==0 -> FAULT.
- FILL: gate_open=1, conveyor off.
  - bottle_full==1 -> ADVANCE; bottle_done pulses in the first ADVANCE cycle.
  - Else bs2==0 -> FAULT. When both occur in the same cycle, bottle_full wins.
- ADVANCE: gate closed, conveyor_on=1 for exactly CONV_CYC cycles. Then -> WAIT_BOTTLE if conti==1, else IDLE.
  - In single mode, the next bottle requires isWork to go low then high again.
- DONE: all drives off. Held until isWork goes low.
- FAULT: fault=1, all drives off. Exits only via RST or isWork low.
- gate_open and conveyor_on are registered and decoded from the next state, so they are never both high. Both are 0 in the cycle the state enters IDLE, DONE, or FAULT.
- Reset mid-operation: outputs are 0 on the next edge. A pill edge in flight is dropped.

Test Plan:
1. RST=1 for 2 cycles; isWork 0->1 with bs2=1 -> state_code 1 then 2; gate_open=1 from the FILL cycle; all outputs were 0 during reset.
2. DEBOUNCE_CYC=4: pill_sense high 10 cycles -> one pill_tick, high exactly 6 edges after sampling; high 3 cycles -> no tick; 5 clean pulses -> 5 ticks.
3. bottle_full asserted in FILL -> gate_open 0, bottle_done one pulse, conveyor_on high exactly 8 cycles. conti=1 -> state 1; conti=0 -> state 0, and the next bottle starts only after an isWork 0->1 toggle.
4. WAIT_BOTTLE with bottle_sense=0 for 64 cycles -> fault=1, state_code 5. Toggling pill_sense produces no ticks. isWork low -> state 0, fault=0.
5. In FILL, bottle_sense drops -> FAULT within 3 cycles. bottle_full and bottle loss in the same cycle -> ADVANCE, not FAULT.
6. allFull asserted during ADVANCE -> DONE next cycle, conveyor_on 0. DONE holds while isWork=1; isWork low -> IDLE.
